// File: rtl/speedy_pkg.sv
// Shared constants and helpers for the SPEEDY S-box arbiter slice.
// Holds the lane geometry, the 6-bit S-box table, the response struct
// and a ceiling-log2 helper for sizing counters and pointers.
package speedy_pkg;

  localparam int LANES   = 32;
  localparam int LANE_W  = 6;
  localparam int STATE_W = LANES * LANE_W;

  // S-box table in the cipher's native MSB-first bit numbering. Lanes in
  // this block keep bit 0 at the LSB, so lookups are wrapped in a reversal.
  localparam logic [LANE_W-1:0] SBOX_TBL [64] = '{
    6'h08, 6'h00, 6'h09, 6'h03, 6'h38, 6'h10, 6'h29, 6'h13,
    6'h0c, 6'h0d, 6'h04, 6'h07, 6'h30, 6'h01, 6'h20, 6'h23,
    6'h1a, 6'h12, 6'h18, 6'h32, 6'h3e, 6'h16, 6'h2c, 6'h36,
    6'h1c, 6'h1d, 6'h14, 6'h37, 6'h34, 6'h05, 6'h24, 6'h27,
    6'h02, 6'h06, 6'h0b, 6'h0f, 6'h33, 6'h17, 6'h21, 6'h15,
    6'h0a, 6'h1b, 6'h0e, 6'h1f, 6'h31, 6'h11, 6'h25, 6'h35,
    6'h22, 6'h26, 6'h2a, 6'h2e, 6'h3a, 6'h1e, 6'h28, 6'h3c,
    6'h2b, 6'h3b, 6'h2f, 6'h3f, 6'h39, 6'h19, 6'h2d, 6'h3d
  };

  // One queued result: S-box output plus the requester that produced it.
  typedef struct packed {
    logic [STATE_W-1:0] data;
    logic [1:0]         src;
  } rsp_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Single 6-bit S-box in LSB-first lane numbering.
  function automatic logic [LANE_W-1:0] sbox6(input logic [LANE_W-1:0] x);
    logic [LANE_W-1:0] xr;
    logic [LANE_W-1:0] y;
    logic [LANE_W-1:0] yr;
    for (int i = 0; i < LANE_W; i++) xr[i] = x[LANE_W-1-i];
    y = SBOX_TBL[xr];
    for (int i = 0; i < LANE_W; i++) yr[i] = y[LANE_W-1-i];
    return yr;
  endfunction

endpackage

// File: rtl/speedy_sbox_layer.sv
// Full SPEEDY S-box layer: 32 independent combinational 6-bit S-boxes,
// lane i at bits [6i+5:6i].
module speedy_sbox_layer
  import speedy_pkg::*;
(
  input  logic [STATE_W-1:0] din,
  output logic [STATE_W-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign dout[i*LANE_W +: LANE_W] = sbox6(din[i*LANE_W +: LANE_W]);
  end

endmodule

// File: rtl/speedy_sbox_arb.sv
// Round-robin arbiter sharing one SPEEDY S-box layer between NREQ
// requesters, with a credit-controlled output FIFO of FIFO_DEPTH entries.
// Optional macro SPEEDY_SBOX_ARB_PIPE_EN inserts a register between the
// grant mux and the S-box layer (latency 2, in-flight counted as credit).
module speedy_sbox_arb
  import speedy_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*STATE_W-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [STATE_W-1:0]      rsp_data,
  output logic [1:0]              rsp_src
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = clog2(FIFO_DEPTH + 1);
`ifdef SPEEDY_SBOX_ARB_PIPE_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  logic [1:0]         ptr_q;
  logic [CW-1:0]      occ_q;
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  rsp_t               mem [FIFO_DEPTH];
  rsp_t               head;

  logic               pop;
  logic               push;
  logic               inflight;
  logic               credit;
  logic               hit;
  logic               gnt_any;
  logic [1:0]         gnt_idx;
  logic [STATE_W-1:0] gdata;
  logic [STATE_W-1:0] lay_in;
  logic [STATE_W-1:0] lay_out;
  logic [1:0]         push_src;
  logic [STAGES:0]    vld_pipe;

  assign rsp_valid = (occ_q != '0);
  assign pop       = rsp_valid & rsp_ready;

  // A slot is free if the entries already owned (queued or in flight)
  // minus the one leaving this cycle leave room; full+pop may still grant.
  assign credit = (int'(occ_q) + int'(inflight)) < (FIFO_DEPTH + int'(pop));

  // Round-robin pick: first valid at or above the pointer, else lowest valid.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (!hit && req_valid[r] && (r >= int'(ptr_q))) begin
        hit     = 1'b1;
        gnt_idx = 2'(r);
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (!hit && req_valid[r]) begin
        hit     = 1'b1;
        gnt_idx = 2'(r);
      end
    end
    gnt_any = hit & credit & rst_n;
  end

  // One-hot ready towards the granted requester and its state mux.
  always_comb begin
    req_ready = '0;
    gdata     = '0;
    for (int r = 0; r < NREQ; r++) begin
      req_ready[r] = gnt_any && (gnt_idx == 2'(r));
      if (gnt_idx == 2'(r)) gdata = req_data[r*STATE_W +: STATE_W];
    end
  end

`ifdef SPEEDY_SBOX_ARB_PIPE_EN
  logic [STAGES:1]    vld_q;
  logic [STATE_W-1:0] stg_data_q;
  logic [1:0]         stg_src_q;

  assign vld_pipe = {vld_q, gnt_any};

  // Valid shift register; a reset drops whatever is in the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];
  end

  // Payload stage between grant mux and S-box layer, loaded on grant.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      stg_data_q <= gdata;
      stg_src_q  <= gnt_idx;
    end
  end

  assign lay_in   = stg_data_q;
  assign push_src = stg_src_q;
  assign inflight = vld_q[STAGES];
`else
  assign vld_pipe = gnt_any;
  assign lay_in   = gdata;
  assign push_src = gnt_idx;
  assign inflight = 1'b0;
`endif

  // Credit was reserved at grant time, so a push never overflows.
  assign push = vld_pipe[STAGES];

  speedy_sbox_layer u_layer (
    .din  (lay_in),
    .dout (lay_out)
  );

  // FIFO payload storage; not reset, the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{data: lay_out, src: push_src};
  end

  // FIFO pointers, occupancy and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ptr_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
      if (gnt_any) ptr_q <= (gnt_idx == 2'(NREQ-1)) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

  assign head     = mem[rd_ptr_q];
  assign rsp_data = rsp_valid ? head.data : '0;
  assign rsp_src  = rsp_valid ? head.src  : 2'd0;

endmodule
